// File: rtl/daq_adc_sequencer_if.sv
// Pin and data-path bundle between the ADC sequencer, the parallel ADC and the packetizer write side.
// data_valid_o is a one-cycle strobe with no ready: data_o/ch_o are valid only in that cycle, and fifo_full_i is sampled once per frame at the trigger, never per word.
interface daq_adc_sequencer_if;
    logic        adc_convst_o;
    logic        adc_cs_n_o;
    logic        adc_rd_n_o;
    logic [2:0]  adc_os_o;
    logic        adc_reset_o;
    logic        adc_busy_i;
    logic [15:0] adc_db_i;
    logic        fifo_full_i;
    logic [15:0] data_o;
    logic [2:0]  ch_o;
    logic        data_valid_o;
    logic        frame_done_o;
    logic        overrun_o;
    logic        drop_o;
    logic        timeout_o;

    modport master (
        output adc_convst_o, adc_cs_n_o, adc_rd_n_o, adc_os_o, adc_reset_o,
        output data_o, ch_o, data_valid_o, frame_done_o, overrun_o, drop_o, timeout_o,
        input  adc_busy_i, adc_db_i, fifo_full_i
    );

    modport slave (
        input  adc_convst_o, adc_cs_n_o, adc_rd_n_o, adc_os_o, adc_reset_o,
        input  data_o, ch_o, data_valid_o, frame_done_o, overrun_o, drop_o, timeout_o,
        output adc_busy_i, adc_db_i, fifo_full_i
    );
endinterface

// File: rtl/daq_adc_sequencer.sv
// Frame-paced conversion controller for an 8-channel 16-bit parallel ADC.
// All pins and strobes are registered, decoded from the next state so they line up with state_q.
module daq_adc_sequencer #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SAMPLE_DIV  = 4000,
    parameter int unsigned CONVST_CYC  = 4,
    parameter int unsigned RD_LO_CYC   = 4,
    parameter int unsigned RD_HI_CYC   = 2,
    parameter int unsigned ADC_RST_CYC = 10,
    parameter int unsigned BUSY_TO     = 2048
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic [2:0]                 os_sel_i,
    output logic [2:0]                 dbg_state_o,
    daq_adc_sequencer_if.master        bus
);
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam int unsigned TMR_W = $clog2(BUSY_TO + ADC_RST_CYC + CONVST_CYC + RD_LO_CYC + RD_HI_CYC);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(ADC_RST_CYC - 1);
    localparam logic [TMR_W-1:0] CONV_LAST  = TMR_W'(CONVST_CYC - 1);
    localparam logic [TMR_W-1:0] RDLO_LAST  = TMR_W'(RD_LO_CYC - 1);
    localparam logic [TMR_W-1:0] RDHI_LAST  = TMR_W'(RD_HI_CYC - 1);
    localparam logic [TMR_W-1:0] BUSY_LAST  = TMR_W'(BUSY_TO - 1);
    localparam logic [2:0]       CH_LAST    = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_ADC_RST = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CONV    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_RD_LO   = 3'd5,
        ST_RD_HI   = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       ch_q, ch_d;
    logic             busy_meta_q, busy_meta_d;
    logic             busy_sync_q, busy_sync_d;
    logic [2:0]       os_q, os_d;
    logic             convst_q, convst_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             adc_reset_q, adc_reset_d;
    logic [15:0]      data_q, data_d;
    logic [2:0]       ch_out_q, ch_out_d;
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic             drop_q, drop_d;
    logic             timeout_q, timeout_d;
    logic             trigger;

    always_comb begin
        trigger      = en_i && (div_q == '0);
        div_d        = en_i ? (trigger ? DIV_RELOAD : div_q - DIV_W'(1)) : DIV_RELOAD;
        busy_meta_d  = bus.adc_busy_i;
        busy_sync_d  = busy_meta_q;

        state_d      = state_q;
        ch_d         = ch_q;
        os_d         = os_q;
        data_d       = data_q;
        ch_out_d     = ch_out_q;
        valid_d      = 1'b0;
        drop_d       = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = trigger && (state_q != ST_IDLE);

        case (state_q)
            // The first cycle after reset has adc_reset low, so the width is counted on the pin itself.
            ST_ADC_RST: if (adc_reset_q && tmr_q == RST_LAST) state_d = ST_IDLE;
            ST_IDLE: begin
                if (trigger) begin
                    if (bus.fifo_full_i) drop_d  = 1'b1;
                    else                 state_d = ST_CONV;
                end else if (os_sel_i != os_q) begin
                    os_d    = os_sel_i;
                    state_d = ST_ADC_RST;
                end
            end
            ST_CONV: if (tmr_q == CONV_LAST) state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (busy_sync_q) begin
                    state_d = ST_WAIT_LO;
                end else if (tmr_q == BUSY_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_ADC_RST;
                end
            end
            ST_WAIT_LO: begin
                if (!busy_sync_q) begin
                    state_d = ST_RD_LO;
                    ch_d    = '0;
                end else if (tmr_q == BUSY_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_ADC_RST;
                end
            end
            ST_RD_LO: begin
                if (tmr_q == RDLO_LAST) begin
                    data_d   = bus.adc_db_i;
                    ch_out_d = ch_q;
                    valid_d  = 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = ST_RD_HI;
                    end
                end
            end
            ST_RD_HI: if (tmr_q == RDHI_LAST) state_d = ST_RD_LO;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_ADC_RST;
        endcase

        if (state_d != state_q || state_q == ST_IDLE || (state_q == ST_ADC_RST && !adc_reset_q)) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        convst_d     = (state_d != ST_CONV);
        cs_n_d       = !(state_d == ST_RD_LO || state_d == ST_RD_HI);
        rd_n_d       = (state_d != ST_RD_LO);
        adc_reset_d  = (state_d == ST_ADC_RST);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_ADC_RST;
            div_q        <= DIV_RELOAD;
            tmr_q        <= '0;
            ch_q         <= '0;
            busy_meta_q  <= 1'b0;
            busy_sync_q  <= 1'b0;
            os_q         <= '0;
            convst_q     <= 1'b1;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            adc_reset_q  <= 1'b0;
            data_q       <= '0;
            ch_out_q     <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            drop_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tmr_q        <= tmr_d;
            ch_q         <= ch_d;
            busy_meta_q  <= busy_meta_d;
            busy_sync_q  <= busy_sync_d;
            os_q         <= os_d;
            convst_q     <= convst_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            adc_reset_q  <= adc_reset_d;
            data_q       <= data_d;
            ch_out_q     <= ch_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            drop_q       <= drop_d;
            timeout_q    <= timeout_d;
        end
    end

    assign dbg_state_o      = state_q;
    assign bus.adc_convst_o = convst_q;
    assign bus.adc_cs_n_o   = cs_n_q;
    assign bus.adc_rd_n_o   = rd_n_q;
    assign bus.adc_os_o     = os_q;
    assign bus.adc_reset_o  = adc_reset_q;
    assign bus.data_o       = data_q;
    assign bus.ch_o         = ch_out_q;
    assign bus.data_valid_o = valid_q;
    assign bus.frame_done_o = frame_done_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.drop_o       = drop_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_daq_adc_sequencer.sv
// Bench for daq_adc_sequencer: behavioural ADC model, sample scoreboard and directed phases.
// The frame divider is shortened so every phase fits in a few thousand cycles.
module tb_daq_adc_sequencer;
    localparam int unsigned TB_DIV  = 256;
    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned BUSY_TO = 2048;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic [2:0]  os_sel_i;
    logic [2:0]  dbg_state_o;
    int unsigned cyc = 0;

    daq_adc_sequencer_if bus();

    daq_adc_sequencer #(.SAMPLE_DIV(TB_DIV)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .os_sel_i    (os_sel_i),
        .dbg_state_o (dbg_state_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [18:0] exp_q[$];
    int          frame_words = 0;
    int          frame_count = 0;
    int          valid_total = 0;
    int          overrun_count = 0;
    int          conv_count = 0;
    int unsigned conv_cycle = 0;
    int unsigned prev_conv_cycle = 0;
    logic        never_busy = 1'b0;
    int          busy_len = 100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ADC model: random words per conversion, BUSY pulse after CONVST, data driven while RD_N is low.
    initial begin : adc_model
        logic [15:0] words[8];
        logic        prev_convst = 1'b1;
        logic        prev_rd = 1'b1;
        int          rd_idx = 0;
        int          busy_wait = 0;
        int          busy_left = 0;
        bus.adc_busy_i = 1'b0;
        bus.adc_db_i   = '0;
        forever begin
            @(negedge clk);
            if (prev_convst && !bus.adc_convst_o) begin
                prev_conv_cycle = conv_cycle;
                conv_cycle      = cyc;
                conv_count++;
                if (!never_busy) begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        words[i] = 16'($urandom_range(0, 65535));
                        exp_q.push_back({3'(i), words[i]});
                    end
                    busy_wait = 3;
                end
            end
            prev_convst = bus.adc_convst_o;
            if (busy_wait > 0) begin
                busy_wait--;
                if (busy_wait == 0) begin
                    bus.adc_busy_i = 1'b1;
                    busy_left      = busy_len;
                end
            end else if (bus.adc_busy_i) begin
                busy_left--;
                if (busy_left <= 0) bus.adc_busy_i = 1'b0;
            end
            if (bus.adc_cs_n_o) begin
                rd_idx  = 0;
                prev_rd = 1'b1;
            end else if (!bus.adc_rd_n_o) begin
                if (rd_idx < 8) bus.adc_db_i = words[rd_idx];
                prev_rd = 1'b0;
            end else if (!prev_rd) begin
                rd_idx++;
                prev_rd = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic [18:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_i) begin
                frame_words = 0;
            end else begin
                if (bus.data_valid_o) begin
                    valid_total++;
                    frame_words++;
                    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("sample", {13'd0, bus.ch_o, bus.data_o}, {13'd0, e});
                    end
                end
                if (bus.frame_done_o) begin
                    frame_count++;
                    check_eq("frame_words", frame_words, NUM_CH);
                    frame_words = 0;
                end
                if (bus.overrun_o) overrun_count++;
            end
        end
    end

    task automatic wait_frames(input int n, input int budget, input string tag);
        int target;
        target = frame_count + n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_count >= target) break;
        end
        check_eq(tag, 32'(frame_count >= target), 1);
    endtask

    task automatic measure_reset_pulse(output int width);
        width = 0;
        for (int i = 0; i < 16 && !bus.adc_reset_o; i++) @(negedge clk);
        while (bus.adc_reset_o && width < 64) begin
            width++;
            @(negedge clk);
        end
    endtask

    initial begin : main
        int   w;
        int   conv_before;
        int   valid_before;
        logic seen;
        reset_i = 1'b1;
        en_i = 1'b0;
        os_sel_i = 3'd0;
        bus.fifo_full_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_convst", bus.adc_convst_o, 1);
        check_eq("rst_cs_n", bus.adc_cs_n_o, 1);
        check_eq("rst_rd_n", bus.adc_rd_n_o, 1);
        check_eq("rst_os", bus.adc_os_o, 0);
        check_eq("rst_adc_reset", bus.adc_reset_o, 0);
        check_eq("rst_data", bus.data_o, 0);
        check_eq("rst_ch", bus.ch_o, 0);
        check_eq("rst_strobes", {bus.data_valid_o, bus.frame_done_o, bus.overrun_o, bus.drop_o, bus.timeout_o}, 0);
        check_eq("rst_state", dbg_state_o, 0);
        reset_i = 1'b0;
        measure_reset_pulse(w);
        check_eq("adc_reset_width", w, 10);

        // Normal frames at the divider rate
        en_i = 1'b1;
        wait_frames(3, 8 * TB_DIV, "normal_frames");
        check_eq("frame_period", conv_cycle - prev_conv_cycle, TB_DIV);
        check_eq("no_overrun", overrun_count, 0);

        // OS change requested mid-frame is applied only after the frame
        for (int i = 0; i < 2 * int'(TB_DIV) && bus.adc_cs_n_o; i++) @(negedge clk);
        check_eq("mid_frame", bus.adc_cs_n_o, 0);
        os_sel_i = 3'd3;
        @(negedge clk);
        check_eq("os_hold_mid", bus.adc_os_o, 0);
        wait_frames(1, TB_DIV, "os_frame");
        check_eq("os_hold_done", bus.adc_os_o, 0);
        conv_before = conv_count;
        measure_reset_pulse(w);
        check_eq("os_reset_width", w, 10);
        check_eq("os_applied", bus.adc_os_o, 3);
        check_eq("no_conv_in_rst", conv_count, conv_before);

        // BUSY never rises: abort after BUSY_TO cycles in WAIT_HI
        never_busy = 1'b1;
        valid_before = valid_total;
        seen = 1'b0;
        for (int i = 0; i < 2 * int'(TB_DIV) + int'(BUSY_TO) + 100; i++) begin
            @(negedge clk);
            if (bus.timeout_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("timeout_seen", seen, 1);
        check_eq("timeout_latency", cyc - conv_cycle, 4 + BUSY_TO);
        check_eq("timeout_to_rst", bus.adc_reset_o, 1);
        check_eq("timeout_no_data", valid_total, valid_before);
        never_busy = 1'b0;
        wait_frames(1, 4 * TB_DIV, "recover_frame");

        // FIFO full at trigger drops the frame without a conversion
        bus.fifo_full_i = 1'b1;
        conv_before = conv_count;
        seen = 1'b0;
        for (int i = 0; i < 2 * int'(TB_DIV); i++) begin
            @(negedge clk);
            if (bus.drop_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("drop_seen", seen, 1);
        check_eq("drop_no_conv", conv_count, conv_before);
        bus.fifo_full_i = 1'b0;
        wait_frames(1, 4 * TB_DIV, "after_drop_frame");

        // BUSY longer than the frame period: triggers are lost, frames stay whole
        overrun_count = 0;
        busy_len = 300;
        wait_frames(3, 12 * TB_DIV, "overrun_frames");
        check_eq("overrun_seen", 32'(overrun_count > 0), 1);
        busy_len = 100;
        wait_frames(1, 4 * TB_DIV, "post_overrun_frame");

        // Reset in the RD_HI gap before channel 3
        seen = 1'b0;
        for (int i = 0; i < 4 * int'(TB_DIV); i++) begin
            @(negedge clk);
            if (frame_words == 3 && !bus.adc_cs_n_o && bus.adc_rd_n_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rd_hi_found", seen, 1);
        reset_i = 1'b1;
        @(negedge clk);
        check_eq("midrst_pins", {bus.adc_convst_o, bus.adc_cs_n_o, bus.adc_rd_n_o}, 3'b111);
        check_eq("midrst_valid", bus.data_valid_o, 0);
        check_eq("midrst_state", dbg_state_o, 0);
        exp_q.delete();
        valid_before = valid_total;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("no_valid_after_rst", valid_total, valid_before);
        wait_frames(1, 4 * TB_DIV, "final_frame");
        @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
